// File: rtl/tail_light_pattern_decoder.sv
// ---------------------------------------------------------------------------
// tail_light_pattern_decoder
//
// Watches the six tail-lamp drive lines of a turn/brake/hazard controller and
// reports which mode the controller is in. Each lamp is filtered through two
// registers so a steadily lit lamp reads as "on" while a PWM-dimmed lamp
// (toggling every cycle) reads as "dim". On every controller step the
// filtered on-levels are classified, checked against the legal sequence of
// frames, and the result is published one cycle later.
//
// Ports
//   dimClk          clock, all state updates on the rising edge
//   reset           synchronous, active-high reset
//   Lc, Lb, La      left lamps, outboard to inboard
//   Ra, Rb, Rc      right lamps, inboard to outboard
//   step            one-cycle pulse per controller state period
//   mode            decoded mode (OFF, BRAKE, LEFT, RIGHT, HAZARD,
//                   BRAKE_LEFT, BRAKE_RIGHT, UNKNOWN)
//   valid           one-cycle pulse: mode/frame updated this cycle
//   seq_err         one-cycle pulse with valid: illegal frame or transition
//   running_lights  dimming activity seen during the last step window
//   frame           last snapshot {Lc,Lb,La,Ra,Rb,Rc} of on-levels
//   err_count       saturating count of seq_err pulses
// ---------------------------------------------------------------------------
module tail_light_pattern_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             dimClk,
    input  logic             reset,
    input  logic             Lc,
    input  logic             Lb,
    input  logic             La,
    input  logic             Ra,
    input  logic             Rb,
    input  logic             Rc,
    input  logic             step,
    output logic [2:0]       mode,
    output logic             valid,
    output logic             seq_err,
    output logic             running_lights,
    output logic [5:0]       frame,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        M_OFF         = 3'd0,
        M_BRAKE       = 3'd1,
        M_LEFT        = 3'd2,
        M_RIGHT       = 3'd3,
        M_HAZARD      = 3'd4,
        M_BRAKE_LEFT  = 3'd5,
        M_BRAKE_RIGHT = 3'd6,
        M_UNKNOWN     = 3'd7
    } mode_t;

    typedef enum logic [3:0] {
        C_OFF, C_ALL,
        C_L1, C_L2, C_L3,
        C_R1, C_R2, C_R3,
        C_BL1, C_BL2,
        C_BR1, C_BR2,
        C_INV
    } code_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [5:0] lamps;
    logic [5:0] cur;
    logic [5:0] prev;
    logic [5:0] on;
    logic [5:0] dim;

    logic       dim_acc;    // any dimming seen since the last step
    logic       pend;       // step sampled last cycle, publish this cycle
    logic [5:0] pend_on;
    logic       pend_dim;

    code_t      code;
    code_t      prev_code;
    code_t      prev2_code;
    mode_t      mode_r;
    mode_t      next_mode;
    logic       illegal;

    assign lamps = {Lc, Lb, La, Ra, Rb, Rc};

    // A lamp lit for two consecutive cycles is on; one that differs between
    // the two samples is being dimmed.
    assign on  = cur & prev;
    assign dim = cur ^ prev;

    assign mode = mode_r;

    // Classify the snapshot taken on the step cycle.
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        code = C_INV;
        case (pend_on)
            6'b000_000: code = C_OFF;
            6'b111_111: code = C_ALL;
            6'b001_000: code = C_L1;
            6'b011_000: code = C_L2;
            6'b111_000: code = C_L3;
            6'b000_100: code = C_R1;
            6'b000_110: code = C_R2;
            6'b000_111: code = C_R3;
            6'b001_111: code = C_BL1;
            6'b011_111: code = C_BL2;
            6'b111_100: code = C_BR1;
            6'b111_110: code = C_BR2;
            default:    code = C_INV;
        endcase
    end

    // Next mode and sequence legality, judged against the last two frames.
    always_comb begin
        next_mode = mode_r;
        illegal   = 1'b0;
        case (code)
            C_ALL: begin
                // A lone ALL is a brake; ALL alternating with OFF is hazard.
                if ((prev2_code == C_ALL && prev_code == C_OFF) ||
                    (mode_r == M_HAZARD && prev_code == C_OFF))
                    next_mode = M_HAZARD;
                else
                    next_mode = M_BRAKE;
            end
            C_OFF: begin
                // OFF is the dark phase of a hazard or turn cycle when it
                // follows the lit end of that cycle.
                if (mode_r == M_HAZARD && prev_code == C_ALL)
                    next_mode = M_HAZARD;
                else if (prev_code == C_L3)
                    next_mode = M_LEFT;
                else if (prev_code == C_R3)
                    next_mode = M_RIGHT;
                else
                    next_mode = M_OFF;
            end
            C_L1: begin
                next_mode = M_LEFT;
                illegal   = prev_code inside {C_L1, C_L2};
            end
            C_L2: begin
                next_mode = M_LEFT;
                illegal   = !(prev_code inside {C_L1, C_BL1});
            end
            C_L3: begin
                next_mode = M_LEFT;
                illegal   = !(prev_code inside {C_L2, C_BL2});
            end
            C_R1: begin
                next_mode = M_RIGHT;
                illegal   = prev_code inside {C_R1, C_R2};
            end
            C_R2: begin
                next_mode = M_RIGHT;
                illegal   = !(prev_code inside {C_R1, C_BR1});
            end
            C_R3: begin
                next_mode = M_RIGHT;
                illegal   = !(prev_code inside {C_R2, C_BR2});
            end
            C_BL1: next_mode = M_BRAKE_LEFT;
            C_BL2: begin
                next_mode = M_BRAKE_LEFT;
                illegal   = !(prev_code inside {C_L1, C_BL1});
            end
            C_BR1: next_mode = M_BRAKE_RIGHT;
            C_BR2: begin
                next_mode = M_BRAKE_RIGHT;
                illegal   = !(prev_code inside {C_R1, C_BR1});
            end
            default: begin
                next_mode = M_UNKNOWN;
                illegal   = 1'b1;
            end
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the values from before this edge.
    always_ff @(posedge dimClk) begin
        if (reset) begin
            cur            <= '0;
            prev           <= '0;
            dim_acc        <= 1'b0;
            pend           <= 1'b0;
            pend_on        <= '0;
            pend_dim       <= 1'b0;
            prev_code      <= C_OFF;
            prev2_code     <= C_OFF;
            mode_r         <= M_OFF;
            valid          <= 1'b0;
            seq_err        <= 1'b0;
            running_lights <= 1'b0;
            frame          <= '0;
            err_count      <= '0;
        end else begin
            cur     <= lamps;
            prev    <= cur;
            valid   <= 1'b0;
            seq_err <= 1'b0;
            pend    <= step;

            // The step cycle's own dimming belongs to the closing window.
            if (step) begin
                pend_on  <= on;
                pend_dim <= dim_acc | (|dim);
                dim_acc  <= 1'b0;
            end else begin
                dim_acc  <= dim_acc | (|dim);
            end

            if (pend) begin
                valid          <= 1'b1;
                seq_err        <= illegal;
                mode_r         <= next_mode;
                frame          <= pend_on;
                running_lights <= pend_dim;
                prev2_code     <= prev_code;
                // An unrecognised frame is remembered as dark so the next
                // frame is judged as if the lamps had been off.
                prev_code      <= (code == C_INV) ? C_OFF : code;
                if (illegal && err_count != '1)
                    err_count <= err_count + CNT_ONE;
            end
        end
    end

endmodule

// File: doc/tail_light_pattern_decoder.md
TAIL_LIGHT_PATTERN_DECODER -- requirements
Module: tail_light_pattern_decoder

Interface
REQ-001 Parameter: CNT_W, 8, width of the saturating error counter.
REQ-002 dimClk  input  1  clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 Lc, Lb, La  input  1 each  left lamp drive, outboard to inboard.
REQ-005 Ra, Rb, Rc  input  1 each  right lamp drive, inboard to outboard.
REQ-006 step  input  1  one-cycle pulse per controller state period; asserted no earlier than 2 dimClk cycles after lamps settle.
REQ-007 mode  output  3  decoded mode: 0 OFF, 1 BRAKE, 2 LEFT, 3 RIGHT, 4 HAZARD, 5 BRAKE_LEFT, 6 BRAKE_RIGHT, 7 UNKNOWN.
REQ-008 valid  output  1  one-cycle pulse; mode/frame updated this cycle.
REQ-009 seq_err  output  1  one-cycle pulse, coincident with valid, illegal frame or transition.
REQ-010 running_lights  output  1  dimming activity seen in last step window.
REQ-011 frame  output  6  last snapshot {Lc,Lb,La,Ra,Rb,Rc}, filtered on-levels.
REQ-012 err_count  output  CNT_W  saturating count of seq_err pulses.

Function
REQ-013 Each lamp SHALL be registered every cycle into cur and prev; lamp on = cur AND prev; lamp dim = cur XOR prev.
REQ-014 A dim flag SHALL accumulate (OR) any lamp dim over the window between steps; it SHALL clear on the cycle step is sampled.
REQ-015 On step, the 6 on-levels SHALL be classified: OFF 000/000, ALL 111/111, L1 001/000, L2 011/000, L3 111/000, R1 000/100, R2 000/110, R3 000/111, BL1 001/111, BL2 011/111, BR1 111/100, BR2 111/110, else INVALID.
REQ-016 Latency: mode, frame, running_lights, seq_err, valid SHALL update on the edge one cycle after the step cycle; outputs hold between updates.
REQ-017 The decoder SHALL keep prev_code and prev2_code (last two frame codes); both OFF after reset.
REQ-018 ALL: mode HAZARD if (prev2,prev)=(ALL,OFF) or mode is HAZARD and prev=OFF; else BRAKE.
REQ-019 OFF: mode stays HAZARD if mode HAZARD and prev=ALL; stays LEFT if prev=L3; stays RIGHT if prev=R3; else OFF.
REQ-020 L1/L2/L3 SHALL set mode LEFT; R1/R2/R3 RIGHT; BL1/BL2 BRAKE_LEFT; BR1/BR2 BRAKE_RIGHT.
REQ-021 Legal predecessors: L2 after L1 or BL1; L3 after L2 or BL2; BL2 after L1 or BL1; mirrored for R2, R3, BR2; L1 not after L1 or L2; R1 not after R1 or R2; violation SHALL pulse seq_err with mode still set per REQ-020.
REQ-022 INVALID SHALL set mode UNKNOWN and pulse seq_err; prev_code SHALL record OFF.
REQ-023 err_count SHALL increment on each seq_err, saturate at 2^CNT_W-1, never wrap.
REQ-024 running_lights SHALL load the accumulated dim flag on each update.
REQ-025 step while a previous update is pending SHALL not occur (step min spacing 2 cycles); no buffering required.

Reset
REQ-026 While reset high: mode=0, valid=0, seq_err=0, running_lights=0, frame=0, err_count=0, cur/prev=0, dim flag=0, prev_code=prev2_code=OFF.
REQ-027 reset and step in the same cycle: reset wins, step discarded, no valid next cycle.
REQ-028 reset mid-sequence: first frame after reset checked against OFF predecessor (L2 immediately after reset pulses seq_err).

Verification
REQ-029 Frames L1,L2,L3,OFF,L1 with steps -> mode 2 each update, seq_err never, err_count 0.
REQ-030 Frames ALL,OFF,ALL,OFF -> modes 1,0,4,4; no seq_err.
REQ-031 Frames R1,R3 -> second update mode 3, seq_err pulse, err_count 1.
REQ-032 Lamps 010/000 on step -> mode 7, seq_err, frame=6'b010000; next OFF frame -> mode 0.
REQ-033 Ra held 1, others toggling each cycle, step -> frame=6'b000100, mode 3, running_lights 1; steady lamps next window -> running_lights 0.
REQ-034 300 INVALID frames with CNT_W=8 -> err_count 255 held; reset -> all outputs 0.
